// File: rtl/wallace_pkg.sv
// Shared widths, row type and pipeline latency for the Wallace-tree multiplier.
// WALLACE_MUL_INREG_EN selects the input-register stage and therefore the latency.
package wallace_pkg;

  localparam int IN_W    = 16;
  localparam int OUT_W   = 33;
  localparam int NUM_LVL = 6;

  localparam int LAT_INREG = 4;
  localparam int LAT_NOREG = 3;
`ifdef WALLACE_MUL_INREG_EN
  localparam int LATENCY = LAT_INREG;
`else
  localparam int LATENCY = LAT_NOREG;
`endif

  // Row count entering each reduction level, plus the final two rows.
  localparam int LVL_ROWS [NUM_LVL+1] = '{16, 11, 8, 6, 4, 3, 2};

  typedef logic [OUT_W-1:0] row_t;

endpackage

// File: rtl/wallace_mul_fa.sv
// One-bit full adder cell; used as a half adder when c_i is tied low.
module wallace_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/wallace_mul_pp.sv
// Pipelined 16x16 unsigned Wallace-tree multiplier, 33-bit registered product.
// WALLACE_MUL_INREG_EN adds the operand register stage (latency 4, else 3).
module wallace_mul_pp
  import wallace_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic [OUT_W-1:0] out
);

  // All reduction rows live in one flat node array; each level reads IN_OFF
  // and writes OUT_OFF. Level 3 reads the S1 register copy at offset 41.
  localparam int NODES  = 56;
  localparam int S1_ROWS = 6;
  localparam int S2_ROWS = 2;
  localparam int IN_OFF  [NUM_LVL] = '{0, 16, 27, 41, 47, 51};
  localparam int OUT_OFF [NUM_LVL] = '{16, 27, 35, 47, 51, 54};
  localparam int S1_D_OFF = 35;
  localparam int S1_Q_OFF = 41;
  localparam int S2_D_OFF = 54;

  logic [IN_W-1:0] a_op;
  logic [IN_W-1:0] b_op;
  row_t            node [NODES];
  row_t            s1_d [S1_ROWS];
  row_t            s1_q [S1_ROWS];
  row_t            s2_d [S2_ROWS];
  row_t            s2_q [S2_ROWS];
  row_t            out_d;
  row_t            out_q;

`ifdef WALLACE_MUL_INREG_EN
  logic [IN_W-1:0] a_q;
  logic [IN_W-1:0] b_q;

  // S0: operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign a_op = a_q;
  assign b_op = b_q;
`else
  assign a_op = a;
  assign b_op = b;
`endif

  genvar l, g, c, r;
  generate
    for (r = 0; r < IN_W; r++) begin : g_pp
      assign node[r] = {{(OUT_W-IN_W){1'b0}}, a_op & {IN_W{b_op[r]}}} << r;
    end

    for (r = 0; r < S1_ROWS; r++) begin : g_s1
      assign s1_d[r]            = node[S1_D_OFF + r];
      assign node[S1_Q_OFF + r] = s1_q[r];
    end

    for (r = 0; r < S2_ROWS; r++) begin : g_s2
      assign s2_d[r] = node[S2_D_OFF + r];
    end

    for (l = 0; l < NUM_LVL; l++) begin : g_lvl
      localparam int N   = LVL_ROWS[l];
      localparam int G   = N / 3;
      localparam int IO  = IN_OFF[l];
      localparam int OO  = OUT_OFF[l];

      for (g = 0; g < G; g++) begin : g_grp
        logic [OUT_W-1:0] sum_s;
        logic [OUT_W-1:0] cy_s;
        for (c = 0; c < OUT_W; c++) begin : g_col
          wallace_fa u_fa (
            .a_i  (node[IO + 3*g][c]),
            .b_i  (node[IO + 3*g + 1][c]),
            .c_i  (node[IO + 3*g + 2][c]),
            .s_o  (sum_s[c]),
            .co_o (cy_s[c])
          );
        end
        // Top carry is provably zero for 16x16 operands and drops off here.
        assign node[OO + 2*g]     = sum_s;
        assign node[OO + 2*g + 1] = OUT_W'({cy_s, 1'b0});
      end

      for (r = 3*G; r < N; r++) begin : g_pass
        assign node[OO + r - G] = node[IO + r];
      end
    end
  endgenerate

  assign out_d = s2_q[0] + s2_q[1];

  // S1/S2/S3: reduction snapshots and final product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S1_ROWS; i++) s1_q[i] <= '0;
      for (int i = 0; i < S2_ROWS; i++) s2_q[i] <= '0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_wallace_mul_pp.sv
// Directed and random checks for wallace_mul_pp in whichever latency mode is built.
module tb_wallace_mul_pp;
  import wallace_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [32:0] out;

  int n_total = 0;
  int n_bad   = 0;

  logic [32:0] pipe [LATENCY];

  logic [15:0] da [8] = '{16'd6, 16'd36, 16'd6, 16'd16, 16'd65535, 16'd0, 16'd65535, 16'd32768};
  logic [15:0] db [8] = '{16'd65, 16'd11, 16'd6, 16'd16, 16'd65535, 16'd65535, 16'd1, 16'd2};
  logic [32:0] dp [8] = '{33'd390, 33'd396, 33'd36, 33'd256, 33'd4294836225, 33'd0, 33'd65535, 33'd65536};

  wallace_mul_pp dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .out (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: product of sampled operands delayed by LATENCY edges
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= 33'(a) * 33'(b);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a   = 16'd0;
    b   = 16'd0;
    #23 rst = 1'b0;
    tick();

    // Fill the pipe so that an asynchronous reset has something to clear
    a = 16'd100;
    b = 16'd100;
    repeat (LATENCY + 1) tick();
    chk("prefill", out, 33'd10000);
    #3 rst = 1'b1;
    #1 chk("rst_async", out, 33'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold", out, 33'd0);
    end
    a = 16'd0;
    b = 16'd0;
    #3 rst = 1'b0;
    repeat (LATENCY + 1) tick();
    chk("rst_release", out, 33'd0);

    // Single products and corners, each held for one cycle
    for (int k = 0; k < 8; k++) begin
      a = da[k];
      b = db[k];
      tick();
      a = 16'd0;
      b = 16'd0;
      repeat (LATENCY - 1) tick();
      chk("directed", out, dp[k]);
      chk("msb_zero", {32'd0, out[32]}, 33'd0);
      repeat (2) tick();
    end

    // Back-to-back stream a=1..20, b=3
    for (int cyc = 0; cyc < 20 + LATENCY; cyc++) begin
      a = (cyc < 20) ? 16'(cyc + 1) : 16'd0;
      b = 16'd3;
      tick();
      if (cyc >= LATENCY - 1 && cyc - (LATENCY - 1) < 20)
        chk("stream", out, 33'(3 * (cyc - (LATENCY - 1) + 1)));
    end

    // Mid-stream reset discards in-flight products
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      chk("pre_rst", out, pipe[LATENCY-1]);
    end
    #2 rst = 1'b1;
    #1 chk("mid_rst", out, 33'd0);
    tick();
    chk("mid_rst_hold", out, 33'd0);
    rst = 1'b0;
    for (int i = 0; i < LATENCY + 6; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      chk("post_rst", out, pipe[LATENCY-1]);
    end

    // Random regression
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      chk("random", out, pipe[LATENCY-1]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
